// File: rtl/mm_sequencer.sv
// mm_sequencer: row-by-row sequencer for C = A * B^T around an external dot-product unit.
// Optional build macro MM_SEQ_CYCLE_COUNT_EN adds a saturating 32-bit per-job cycle counter.
module mm_sequencer #(
    parameter int BATCH_SIZE          = 8,
    parameter int LOG_BATCH_SIZE      = 3,
    parameter int OUTPUT_FEATURES     = 8,
    parameter int LOG_OUTPUT_FEATURES = 3,
    parameter int OUTPUT_WIDTH        = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    done,
`ifdef MM_SEQ_CYCLE_COUNT_EN
    output logic [31:0]                             cycleCount,
`endif
    output logic [LOG_BATCH_SIZE-1:0]               inputAddr,
    output logic                                    inputRdEn,
    output logic [LOG_OUTPUT_FEATURES-1:0]          weightAddr,
    output logic                                    weightRdEn,
    output logic                                    dpValid,
    input  logic [OUTPUT_WIDTH-1:0]                 dpResult,
    input  logic                                    dpResultValid,
    output logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] outputData,
    output logic [LOG_BATCH_SIZE-1:0]               outputAddr,
    output logic                                    outputWrEn,
    input  logic                                    outputReady
);

    localparam int RW = LOG_OUTPUT_FEATURES + 1;
    localparam logic [LOG_BATCH_SIZE-1:0]      B_LAST = LOG_BATCH_SIZE'(BATCH_SIZE - 1);
    localparam logic [LOG_OUTPUT_FEATURES-1:0] O_LAST = LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);
    localparam logic [RW-1:0]                  R_FULL = RW'(OUTPUT_FEATURES);
    localparam logic [RW-1:0]                  R_LAST = RW'(OUTPUT_FEATURES - 1);

    typedef enum logic [2:0] {IDLE, LOAD_A, ISSUE, DRAIN, WRITE, DONE} stateT;

    stateT                          state;
    stateT                          nextState;
    logic [LOG_BATCH_SIZE-1:0]      b;
    logic [LOG_OUTPUT_FEATURES-1:0] o;
    logic [RW-1:0]                  r;
    logic                           laneWrite;

    // Results are only accepted while a row is being gathered, and never beyond the last lane.
    assign laneWrite = dpResultValid && (r != R_FULL) && ((state == ISSUE) || (state == DRAIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        nextState  = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        inputRdEn  = 1'b0;
        weightRdEn = 1'b0;
        outputWrEn = 1'b0;
        inputAddr  = b;
        weightAddr = o;
        outputAddr = b;
        unique case (state)
            IDLE:   if (start) nextState = LOAD_A;
            LOAD_A: begin
                inputRdEn = 1'b1;
                nextState = ISSUE;
            end
            ISSUE: begin
                weightRdEn = 1'b1;
                if (o == O_LAST) nextState = DRAIN;
            end
            // Look ahead at the final result so WRITE follows it without a bubble.
            DRAIN:  if ((r == R_FULL) || ((r == R_LAST) && laneWrite)) nextState = WRITE;
            WRITE: begin
                outputWrEn = 1'b1;
                if (outputReady) nextState = (b == B_LAST) ? DONE : LOAD_A;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b       <= '0;
            o       <= '0;
            r       <= '0;
            dpValid <= 1'b0;
        end else begin
            dpValid <= weightRdEn;
            unique case (state)
                IDLE:   if (start) b <= '0;
                LOAD_A: begin
                    o <= '0;
                    r <= '0;
                end
                ISSUE:  o <= o + 1'b1;
                WRITE:  if (outputReady && (b != B_LAST)) b <= b + 1'b1;
                default: ;
            endcase
            if (laneWrite) r <= r + 1'b1;
        end
    end

    // NOTE: the row buffer is reset as well, because it drives a port that must read 0 under reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outputData <= '0;
        end else if (laneWrite) begin
            for (int k = 0; k < OUTPUT_FEATURES; k++) begin
                if (r == RW'(k)) outputData[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] <= dpResult;
            end
        end
    end

`ifdef MM_SEQ_CYCLE_COUNT_EN
    // The LOAD_A cycle entered on start is already a busy cycle, so the count restarts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycleCount <= '0;
        end else if ((state == IDLE) && start) begin
            cycleCount <= 32'd1;
        end else if ((state != IDLE) && (state != DONE) && (cycleCount != '1)) begin
            cycleCount <= cycleCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mm_sequencer.sv
// tb_mm_sequencer: directed scoreboard bench for mm_sequencer with a latency-2 dot-product model.
// Define MM_SEQ_CYCLE_COUNT_EN for both files to also exercise cycleCount.
module tb_mm_sequencer;

    localparam int M  = 8;
    localparam int LM = 3;
    localparam int O  = 8;
    localparam int LO = 3;
    localparam int W  = 16;
    localparam int DW = O * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [LM-1:0] inputAddr;
    logic          inputRdEn;
    logic [LO-1:0] weightAddr;
    logic          weightRdEn;
    logic          dpValid;
    logic [W-1:0]  dpResult;
    logic          dpResultValid;
    logic [DW-1:0] outputData;
    logic [LM-1:0] outputAddr;
    logic          outputWrEn;
    logic          outputReady;
`ifdef MM_SEQ_CYCLE_COUNT_EN
    logic [31:0]   cycleCount;
`endif

    typedef struct {
        logic [LM-1:0] addr;
        logic [DW-1:0] data;
    } wrT;

    wrT sb[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int lastWr = 0;
    int doneCount = 0;
    bit gapCheck = 1'b0;
    bit rowMode = 1'b0;
    bit extraEn = 1'b0;
    bit extraDone = 1'b0;
    bit pipe0 = 1'b0;
    bit pipe1 = 1'b0;
    int aRow = 0;
    int resCount = 0;

    mm_sequencer #(
        .BATCH_SIZE(M), .LOG_BATCH_SIZE(LM), .OUTPUT_FEATURES(O),
        .LOG_OUTPUT_FEATURES(LO), .OUTPUT_WIDTH(W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
`ifdef MM_SEQ_CYCLE_COUNT_EN
        .cycleCount(cycleCount),
`endif
        .inputAddr(inputAddr), .inputRdEn(inputRdEn),
        .weightAddr(weightAddr), .weightRdEn(weightRdEn), .dpValid(dpValid),
        .dpResult(dpResult), .dpResultValid(dpResultValid),
        .outputData(outputData), .outputAddr(outputAddr),
        .outputWrEn(outputWrEn), .outputReady(outputReady)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] dpVal(input int row, input int k);
        logic [W-1:0] v;
        v = 16'h0100 + W'(k);
        if (rowMode) v = v + W'(row * 16);
        return v;
    endfunction

    function automatic logic [DW-1:0] expRow(input int row);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < O; k++) d[k*W +: W] = dpVal(row, k);
        return d;
    endfunction

    task automatic pushJob();
        for (int row = 0; row < M; row++) sb.push_back('{addr: LM'(row), data: expRow(row)});
    endtask

    task automatic pulseStart();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic waitLoad(input int row);
        int i;
        for (i = 0; i < 400; i++) begin
            if (inputRdEn && (inputAddr == LM'(row))) break;
            @(negedge clk);
        end
        check($sformatf("load_row%0d_seen", row), DW'(i < 400), DW'(1));
    endtask

    task automatic waitDone(input string tag);
        int i;
        for (i = 0; i < 600; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check(tag, DW'(done), DW'(1));
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_busy"}, DW'(busy), DW'(0));
        check({tag, "_done"}, DW'(done), DW'(0));
        check({tag, "_inputRdEn"}, DW'(inputRdEn), DW'(0));
        check({tag, "_weightRdEn"}, DW'(weightRdEn), DW'(0));
        check({tag, "_dpValid"}, DW'(dpValid), DW'(0));
        check({tag, "_outputWrEn"}, DW'(outputWrEn), DW'(0));
        check({tag, "_inputAddr"}, DW'(inputAddr), DW'(0));
        check({tag, "_weightAddr"}, DW'(weightAddr), DW'(0));
        check({tag, "_outputAddr"}, DW'(outputAddr), DW'(0));
        check({tag, "_outputData"}, outputData, DW'(0));
`ifdef MM_SEQ_CYCLE_COUNT_EN
        check({tag, "_cycleCount"}, DW'(cycleCount), DW'(0));
`endif
    endtask

    // Dot-product model: a result appears two cycles after each dpValid, values in lane order.
    initial begin
        dpResultValid = 1'b0;
        dpResult      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pipe0 = 1'b0;
                pipe1 = 1'b0;
                dpResultValid = 1'b0;
                resCount = 0;
            end else begin
                if (inputRdEn) begin
                    aRow = int'(inputAddr);
                    resCount = 0;
                    extraDone = 1'b0;
                end
                dpResultValid = pipe1;
                if (pipe1) begin
                    dpResult = dpVal(aRow, resCount);
                    resCount++;
                end else if (extraEn && (resCount == O) && !extraDone) begin
                    dpResultValid = 1'b1;
                    dpResult = 16'hDEAD;
                    extraDone = 1'b1;
                end
                pipe1 = pipe0;
                pipe0 = dpValid;
            end
        end
    end

    // Write monitor: every accepted row is popped from the scoreboard and compared.
    always @(negedge clk) begin : monitor
        wrT e;
        cyc++;
        if (!rst) begin
            check("strobes_exclusive", DW'($onehot0({inputRdEn, weightRdEn, outputWrEn})), DW'(1));
            if (done) doneCount++;
            if (outputWrEn && outputReady) begin
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_write: observed addr %0d expected no write", outputAddr);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("wr_addr", DW'(outputAddr), DW'(e.addr));
                    check("wr_data", outputData, e.data);
                end
                if (gapCheck && (outputAddr != '0)) check("wr_gap", DW'(cyc - lastWr), DW'(13));
                lastWr = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion expected finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] held;
        int n;
        bit pulsed;
        rst = 1'b1;
        start = 1'b0;
        outputReady = 1'b1;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_start_busy", DW'(busy), DW'(0));

        // Job A: plain lane data, row spacing, done latency, start ignored while busy.
        rowMode = 1'b0;
        gapCheck = 1'b1;
        pushJob();
        pulseStart();
        n = 1;
        pulsed = 1'b0;
        while (!done && (n < 400)) begin
            if (start) start = 1'b0;
            else if (!pulsed && inputRdEn && (inputAddr == LM'(2))) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("done_latency", DW'(n), DW'(105));
`ifdef MM_SEQ_CYCLE_COUNT_EN
        check("cycle_count_at_done", DW'(cycleCount), DW'(105));
`endif
        @(negedge clk);
        check("done_one_cycle", DW'(done), DW'(0));
        check("idle_after_done", DW'(busy), DW'(0));
        repeat (9) @(negedge clk);
`ifdef MM_SEQ_CYCLE_COUNT_EN
        check("cycle_count_frozen", DW'(cycleCount), DW'(105));
`endif
        repeat (20) @(negedge clk);
        check("job_a_done_count", DW'(doneCount), DW'(1));
        check("job_a_no_restart", DW'(busy), DW'(0));
        check("job_a_sb_empty", DW'(sb.size()), DW'(0));
        gapCheck = 1'b0;

        // Job B: row-tagged data, row-3 write stalled 5 cycles, stray result after the last lane.
        rowMode = 1'b1;
        extraEn = 1'b1;
        pushJob();
        pulseStart();
        waitLoad(3);
        outputReady = 1'b0;
        for (n = 0; n < 100; n++) begin
            if (outputWrEn) break;
            @(negedge clk);
        end
        check("stall_write_seen", DW'(outputWrEn), DW'(1));
        held = outputData;
        check("stall_row3_data", held, expRow(3));
        for (int i = 0; i < 6; i++) begin
            check($sformatf("stall_wren_c%0d", i), DW'(outputWrEn), DW'(1));
            check($sformatf("stall_addr_c%0d", i), DW'(outputAddr), DW'(3));
            check($sformatf("stall_data_c%0d", i), outputData, held);
            check($sformatf("stall_no_reads_c%0d", i), DW'({inputRdEn, weightRdEn}), DW'(0));
            if (i == 4) begin
                @(posedge clk);
                #1 outputReady = 1'b1;
            end
            @(negedge clk);
        end
        check("stall_released", DW'(outputWrEn), DW'(0));
        waitDone("job_b_done");
        @(negedge clk);
        extraEn = 1'b0;
        repeat (5) @(negedge clk);
        check("job_b_done_count", DW'(doneCount), DW'(2));
        check("job_b_sb_empty", DW'(sb.size()), DW'(0));

        // Job C: reset during ISSUE of row 4 aborts the job without done.
        pushJob();
        pulseStart();
        waitLoad(4);
        @(negedge clk);
        check("abort_in_issue", DW'(weightRdEn), DW'(1));
        #2 rst = 1'b1;
        #1 checkAllZero("abort");
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", DW'(doneCount), DW'(2));
        check("abort_idle", DW'(busy), DW'(0));

        // Job D: a fresh start after the abort completes all rows.
        pushJob();
        pulseStart();
        waitDone("job_d_done");
        repeat (5) @(negedge clk);
        check("job_d_done_count", DW'(doneCount), DW'(3));
        check("job_d_sb_empty", DW'(sb.size()), DW'(0));
        check("job_d_idle", DW'(busy), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
